// File: rtl/cut_seq_pkg.sv
// Shared types and helpers for the CUT vector sequencer: FSM state encoding,
// LFSR feedback taps and a saturating counter increment.
package cut_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CMP    = 2'd2
  } state_t;

  // x^12 + x^6 + x^4 + x + 1, x^12 implied by the shifted-out MSB
  localparam logic [11:0] LFSR_TAPS = 12'h053;

  localparam int CNT_W_DEF = 16;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cut_lfsr12.sv
// 12-bit Galois LFSR for random stimulus; a zero seed is replaced by 1 so the
// generator can never lock up in the all-zero state.
module cut_lfsr12
  import cut_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] seed,
  input  logic        adv,
  output logic [11:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 12'h001;
    end else if (load) begin
      state <= (seed == 12'h000) ? 12'h001 : seed;
    end else if (adv) begin
      state <= {state[10:0], 1'b0} ^ (state[11] ? LFSR_TAPS : 12'h000);
    end
  end

endmodule

// File: rtl/cut_vector_sequencer.sv
// Drives a golden and a revised CUT from one registered input bus, choosing
// between directed and LFSR vectors, then compares and records mismatches.
module cut_vector_sequencer
  import cut_seq_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             dir_valid,
  input  logic [IN_W-1:0]  dir_vec,
  output logic             dir_ready,
  input  logic             rnd_start,
  input  logic [IN_W-1:0]  rnd_seed,
  input  logic [CNT_W-1:0] rnd_num,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] res_a,
  input  logic [OUT_W-1:0] res_b,
  output logic             busy,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic             mis_valid,
  output logic [IN_W-1:0]  mis_vec,
  output logic [OUT_W-1:0] mis_diff
);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [CNT_W-1:0] rnd_left;
  logic             rr_rnd;
  logic             rnd_req;
  logic             grant_dir;
  logic             grant_rnd;
  logic             rnd_load;
  logic [11:0]      lfsr_state;

  assign rnd_req  = (rnd_left != '0);
  assign rnd_load = rnd_start && !rnd_req && !clr;
  assign busy     = (state != ST_IDLE) || rnd_req;

  // Handshake: a directed vector transfers on a rising edge where
  // dir_valid && dir_ready; dir_vec must hold while valid waits for ready.
  // Grants happen only in IDLE and never while clr is high.
  always_comb begin
    grant_dir = 1'b0;
    grant_rnd = 1'b0;
    if (state == ST_IDLE && !clr) begin
      if (dir_valid && (!rnd_req || !rr_rnd)) begin
        grant_dir = 1'b1;
      end else if (rnd_req) begin
        grant_rnd = 1'b1;
      end
    end
  end

  assign dir_ready = grant_dir;

  cut_lfsr12 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (rnd_load),
    .seed  (12'(rnd_seed)),
    .adv   (grant_rnd),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      rnd_left   <= '0;
      rr_rnd     <= 1'b0;
      cut_in     <= '0;
      vec_cnt    <= '0;
      mis_cnt    <= '0;
      mis_valid  <= 1'b0;
      mis_vec    <= '0;
      mis_diff   <= '0;
    end else if (clr) begin
      // cut_in and the LFSR keep their values; any in-flight vector is dropped
      state     <= ST_IDLE;
      rnd_left  <= '0;
      vec_cnt   <= '0;
      mis_cnt   <= '0;
      mis_valid <= 1'b0;
      mis_vec   <= '0;
      mis_diff  <= '0;
    end else begin
      if (rnd_load) begin
        rnd_left <= rnd_num;
      end else if (grant_rnd) begin
        rnd_left <= rnd_left - 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant_dir || grant_rnd) begin
            cut_in     <= grant_dir ? dir_vec : IN_W'(lfsr_state);
            settle_cnt <= 4'(SETTLE - 1);
            rr_rnd     <= grant_dir;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CMP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CMP: begin
          vec_cnt <= CNT_W'(sat_inc(32'(vec_cnt), CNT_W));
          if (res_a != res_b) begin
            mis_cnt <= CNT_W'(sat_inc(32'(mis_cnt), CNT_W));
            if (!mis_valid) begin
              mis_valid <= 1'b1;
              mis_vec   <= cut_in;
              mis_diff  <= res_a ^ res_b;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cut_vector_sequencer.md
Name: cut_vector_sequencer

Overview:
- Sequences stimulus into a pair of 12-input / 4-output combinational circuits under test (CUT A = golden, CUT B = revised) and compares their responses.
- Arbitrates between two vector requesters: an external directed-vector port and an internal LFSR random generator.
- Drives one shared registered input bus, waits a programmable settle time, captures both outputs, and counts vectors and mismatches.
- Sits beside the case circuits in the equivalence-check harness as their only driver.

Parameters:
- IN_W, 12, CUT primary-input width.
- OUT_W, 4, CUT primary-output width.
- SETTLE, 2, cycles between cut_in update and capture; legal range 1..15.
- CNT_W, 16, width of vector and mismatch counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of counters, mismatch record and FSM.
- dir_valid  in  1  directed vector offered.
- dir_vec  in  IN_W  directed vector.
- dir_ready  out  1  directed vector accepted this cycle.
- rnd_start  in  1  pulse: load LFSR seed and random count.
- rnd_seed  in  IN_W  LFSR seed.
- rnd_num  in  CNT_W  number of random vectors to issue.
- cut_in  out  IN_W  registered stimulus to both CUTs; bit i is CUT primary input i in declaration order.
- res_a  in  OUT_W  CUT A outputs.
- res_b  in  OUT_W  CUT B outputs.
- busy  out  1  FSM not in IDLE, or random vectors remaining.
- vec_cnt  out  CNT_W  vectors compared, saturating.
- mis_cnt  out  CNT_W  mismatching vectors, saturating.
- mis_valid  out  1  a first mismatch has been recorded.
- mis_vec  out  IN_W  stimulus of the first mismatch.
- mis_diff  out  OUT_W  res_a XOR res_b at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; cut_in 0; FSM IDLE.
  - LFSR = 1; rnd_left 0; RR pointer favours directed.
- FSM states: IDLE, SETTLE, CMP.
- IDLE → SETTLE when a request is granted:
  - cut_in <= granted vector; settle counter <= SETTLE-1.
  - Directed grant: dir_ready=1 for exactly that cycle.
  - Random grant: LFSR advances; rnd_left decrements.
- SETTLE: decrement counter each cycle; at 0 → CMP.
- CMP, one cycle:
  - vec_cnt += 1.
  - If res_a != res_b: mis_cnt += 1. If mis_valid==0, set mis_valid=1 and latch mis_vec=cut_in, mis_diff=res_a^res_b.
  - Then → IDLE.
- Latency: grant at cycle T, cut_in valid T+1, compare at T+SETTLE+1. Throughput is one vector per SETTLE+2 cycles.
- dir_ready is combinational from state and arbitration; it is never asserted outside IDLE. dir_vec must be held stable while dir_valid=1 and dir_ready=0.
- Arbitration, both requesting in IDLE: round-robin; the pointer flips to the other requester after each grant. With a single requester, that requester is granted.
- Random requester requests while rnd_left != 0.
- LFSR: 12-bit Galois, polynomial x^12+x^6+x^4+x+1. Output the current state, then advance.
- rnd_start:
  - When rnd_left==0: load LFSR=rnd_seed (0 is replaced by 1) and rnd_left=rnd_num.
  - When rnd_left!=0: ignored.
  - rnd_num=0 issues nothing.
- Counters saturate at all-ones; no wrap.
- mis_vec and mis_diff hold until clr or reset; later mismatches only increment mis_cnt.
- clr:
  - Zeroes vec_cnt, mis_cnt, mis_valid, mis_vec, mis_diff and rnd_left; FSM → IDLE.
  - An in-flight vector is dropped, not counted, even if clr coincides with CMP.
  - clr has priority over grant in the same cycle (dir_ready=0).
  - cut_in and LFSR state are retained.
- Reset mid-operation: immediate return to reset values; no partial counts.

Decomposition:
- Package cut_seq_pkg: state enum (IDLE, SETTLE, CMP), LFSR tap constant 12'h053, CNT_W default, saturating-increment function.
- One sub-module, cut_lfsr12: seed load, advance enable, state output, zero-seed guard.
- Arbiter, FSM and compare/record logic stay in the top.

Test Plan:
- Directed single vector: dir_vec=12'hA5C, res_a=res_b=4'h3 → dir_ready 1 cycle, cut_in=12'hA5C one cycle later, vec_cnt=1, mis_cnt=0, mis_valid=0 at T+SETTLE+2.
- Mismatch capture: vectors 12'h001 (res_a=4'h5, res_b=4'h4) then 12'h002 (res_a=4'h0, res_b=4'hF) → mis_cnt=2, mis_vec=12'h001, mis_diff=4'h1.
- Random run: rnd_seed=0, rnd_num=5 → first cut_in=12'h001, exactly 5 vectors, sequence matches the polynomial model, busy falls after the 5th CMP.
- Contention: dir_valid held high while random run rnd_num=4 is active → grants alternate D,R,D,R starting with D after reset.
- clr in CMP cycle with res_a!=res_b → vec_cnt=0, mis_cnt=0, mis_valid=0; FSM in IDLE next cycle.
- Saturation: CNT_W=4, 17 mismatching vectors → vec_cnt=mis_cnt=4'hF. Assert rst_n low mid-SETTLE → all outputs 0 asynchronously.
